// File: rtl/hilo_div_ctrl_if.sv
// Bundle between the HI/LO divide controller, its requester and the iterative divider.
// The slave side is the controller; the master side is the requester plus divider.
interface hilo_div_ctrl_if;
  logic        op_valid;
  logic [1:0]  op;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        div_start;
  logic [31:0] div_a;
  logic [31:0] div_b;
  logic        div_rst;
  logic        div_busy;
  logic        div_done;
  logic        div_dbz;
  logic [31:0] div_val;
  logic [31:0] div_rem;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        stall;
  logic        op_done;
  logic        dbz_exc;
  logic        tmo_exc;

  modport slave (
    input  op_valid, op, op_a, op_b, div_busy, div_done, div_dbz, div_val, div_rem,
    output div_start, div_a, div_b, div_rst, hi, lo, stall, op_done, dbz_exc, tmo_exc
  );

  modport master (
    output op_valid, op, op_a, op_b, div_busy, div_done, div_dbz, div_val, div_rem,
    input  div_start, div_a, div_b, div_rst, hi, lo, stall, op_done, dbz_exc, tmo_exc
  );
endinterface

// File: rtl/hilo_div_ctrl.sv
// HI/LO register controller: MTHI/MTLO writes and sequencing of an external divider
// with divide-by-zero and watchdog-timeout handling.
//
// state | meaning
// IDLE  | accept MTHI/MTLO/DIV requests, stall low
// START | div_start asserted for one cycle, watchdog cleared
// WAIT  | waiting for div_done, watchdog counting
// CLEAR | div_rst asserted for one cycle, then back to IDLE
module hilo_div_ctrl #(
  parameter int TIMEOUT = 64
) (
  input  logic            clk,
  input  logic            rst,
  hilo_div_ctrl_if.slave  bus
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, START, WAIT, CLEAR} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic          sign_a;
  logic [31:0]   hi_q;
  logic [31:0]   lo_q;
  logic [31:0]   a_q;
  logic [31:0]   b_q;
  logic          start_q;
  logic          div_rst_q;
  logic          done_q;
  logic          dbz_q;
  logic          tmo_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= '0;
      sign_a    <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      start_q   <= 1'b0;
      div_rst_q <= 1'b1;
      done_q    <= 1'b0;
      dbz_q     <= 1'b0;
      tmo_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      dbz_q  <= 1'b0;
      tmo_q  <= 1'b0;
      unique case (state)
        IDLE: begin
          div_rst_q <= 1'b0;
          if (bus.op_valid) begin
            unique case (bus.op)
              2'b00: begin
                a_q     <= bus.op_a;
                b_q     <= bus.op_b;
                sign_a  <= bus.op_a[31];
                start_q <= 1'b1;
                state   <= START;
              end
              2'b01:   hi_q <= bus.op_a;
              2'b10:   lo_q <= bus.op_a;
              default: ;
            endcase
          end
        end
        START: begin
          start_q <= 1'b0;
          cnt     <= '0;
          state   <= WAIT;
        end
        WAIT: begin
          if (bus.div_done) begin
            if (bus.div_dbz) begin
              dbz_q <= 1'b1;
            end else begin
              // divider reports remainder magnitude; its sign follows the dividend
              lo_q   <= bus.div_val;
              hi_q   <= sign_a ? (~bus.div_rem + 32'd1) : bus.div_rem;
              done_q <= 1'b1;
            end
            div_rst_q <= 1'b1;
            state     <= CLEAR;
          end else if (cnt == CNT_LAST) begin
            tmo_q     <= 1'b1;
            div_rst_q <= 1'b1;
            state     <= CLEAR;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        CLEAR: begin
          div_rst_q <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.div_start = start_q;
  assign bus.div_a     = a_q;
  assign bus.div_b     = b_q;
  assign bus.div_rst   = div_rst_q;
  assign bus.hi        = hi_q;
  assign bus.lo        = lo_q;
  assign bus.stall     = (state != IDLE);
  assign bus.op_done   = done_q;
  assign bus.dbz_exc   = dbz_q;
  assign bus.tmo_exc   = tmo_q;

endmodule
